// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, EX backpressure hold,
// branch-flush kill and saturating bubble/flush performance counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ID_W   = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ID_W-1:0]   id_instr_id,
    input  logic              id_rs1_re,
    input  logic              id_rs2_re,
    input  logic              id_rd_we,
    input  logic              id_mem_re,
    input  logic              id_mem_we,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              ex_ready,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic [ID_W-1:0]   ex_instr_id,
    output logic              ex_rs1_re,
    output logic              ex_rs2_re,
    output logic              ex_rd_we,
    output logic              ex_mem_re,
    output logic              ex_mem_we,
    output logic [REG_AW-1:0] ex_rs1_addr,
    output logic [REG_AW-1:0] ex_rs2_addr,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [ID_W-1:0]   instr_id;
        logic              rs1_re;
        logic              rs2_re;
        logic              rd_we;
        logic              mem_re;
        logic              mem_we;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } entry_t;

    entry_t           id_entry;
    entry_t           entry_p1;
    logic             vld_p1;
    logic             hazard;
    logic             rs1_hit;
    logic             rs2_hit;
    logic [CNT_W-1:0] bubble_cnt_p1;
    logic [CNT_W-1:0] flush_cnt_p1;

    // Saturating increment: stays at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    // Load-use detection against the load currently sitting in EX, and handshake.
    always_comb begin
        rs1_hit  = id_rs1_re && (id_rs1_addr == entry_p1.rd_addr);
        rs2_hit  = id_rs2_re && (id_rs2_addr == entry_p1.rd_addr);
        hazard   = id_valid && vld_p1 && entry_p1.mem_re && entry_p1.rd_we &&
                   (entry_p1.rd_addr != '0) && (rs1_hit || rs2_hit);
        id_ready = ex_ready && !hazard && !ex_flush;
    end

    // Gather ID fields; a write to x0 is dropped here so EX never sees it.
    always_comb begin
        id_entry          = '0;
        id_entry.instr_id = id_instr_id;
        id_entry.rs1_re   = id_rs1_re;
        id_entry.rs2_re   = id_rs2_re;
        id_entry.rd_we    = id_rd_we && (id_rd_addr != '0);
        id_entry.mem_re   = id_mem_re;
        id_entry.mem_we   = id_mem_we;
        id_entry.rs1_addr = id_rs1_addr;
        id_entry.rs2_addr = id_rs2_addr;
        id_entry.rd_addr  = id_rd_addr;
        id_entry.rs1_data = id_rs1_data;
        id_entry.rs2_data = id_rs2_data;
        id_entry.imm      = id_imm;
        id_entry.pc       = id_pc;
    end

    // ID -> EX register: flush, hold, hazard bubble, load, idle bubble (in priority order).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (ex_flush) begin
            entry_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (!ex_ready) begin
            entry_p1 <= entry_p1;
            vld_p1   <= vld_p1;
        end else if (hazard || !id_valid) begin
            entry_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            entry_p1 <= id_entry;
            vld_p1   <= 1'b1;
        end
    end

    // Performance counters: inserted load-use bubbles and killed valid instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_p1 <= '0;
            flush_cnt_p1  <= '0;
        end else if (ex_flush) begin
            if (id_valid) flush_cnt_p1 <= sat_inc(flush_cnt_p1);
        end else if (ex_ready && hazard) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end
    end

    assign load_use_stall = hazard;
    assign ex_valid       = vld_p1;
    assign ex_instr_id    = entry_p1.instr_id;
    assign ex_rs1_re      = entry_p1.rs1_re;
    assign ex_rs2_re      = entry_p1.rs2_re;
    assign ex_rd_we       = entry_p1.rd_we;
    assign ex_mem_re      = entry_p1.mem_re;
    assign ex_mem_we      = entry_p1.mem_we;
    assign ex_rs1_addr    = entry_p1.rs1_addr;
    assign ex_rs2_addr    = entry_p1.rs2_addr;
    assign ex_rd_addr     = entry_p1.rd_addr;
    assign ex_rs1_data    = entry_p1.rs1_data;
    assign ex_rs2_data    = entry_p1.rs2_data;
    assign ex_imm         = entry_p1.imm;
    assign ex_pc          = entry_p1.pc;
    assign bubble_cnt     = bubble_cnt_p1;
    assign flush_cnt      = flush_cnt_p1;

endmodule
